// File: rtl/lzrw_decompressor.sv
// LZRW token decompressor: expands literal and {length, offset} copy tokens
// into a byte stream using an on-chip history buffer.
// Optional feature: define LZRW_DECOMP_OFFSET_CHECK_EN to drop copies whose
// offset is zero or reaches beyond the bytes written so far (sticky offset_err).
module lzrw_decompressor #(
   parameter  int unsigned HISTORY_SIZE = 4096,
   parameter  int unsigned LENGTH_WIDTH = 4,
   localparam int unsigned OFFSET_WIDTH = $clog2(HISTORY_SIZE),
   localparam int unsigned TOKEN_WIDTH  = LENGTH_WIDTH + OFFSET_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [TOKEN_WIDTH-1:0] in_token,
   input  logic                   in_is_copy,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [7:0]             out_byte,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   offset_err
);

   localparam int unsigned COUNT_WIDTH = LENGTH_WIDTH + 1;

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] COPY_PRIME = 2'd1;
   localparam logic [1:0] COPY       = 2'd2;

   logic [1:0]              state, state_nxt;
   logic [OFFSET_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
   logic [OFFSET_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
   logic [COUNT_WIDTH-1:0]  count, count_nxt;
   logic [7:0]              out_byte_nxt;
   logic                    out_valid_nxt;
   logic                    ready_en;
   logic                    mem_we;
   logic [7:0]              mem_wdata;
   logic                    copy_ok;
   logic                    copy_drop;
   logic                    tok_xfer;
   logic                    out_xfer;
   logic [7:0]              hist [HISTORY_SIZE];

   logic [LENGTH_WIDTH-1:0] tok_len;
   logic [OFFSET_WIDTH-1:0] tok_off;

   assign tok_len = in_token[TOKEN_WIDTH-1 -: LENGTH_WIDTH];
   assign tok_off = in_token[OFFSET_WIDTH-1:0];

   // Handshakes: tokens only enter in IDLE once the output register can take a byte
   assign in_ready = ready_en & (state == IDLE) & (~out_valid | out_ready);
   assign tok_xfer = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;
   assign busy     = (state != IDLE) | out_valid;

`ifdef LZRW_DECOMP_OFFSET_CHECK_EN
   localparam int unsigned FILL_MAX = (HISTORY_SIZE > 65535) ? 65535 : HISTORY_SIZE;

   logic [15:0] fill_cnt;
   logic        offset_err_q;

   assign copy_ok    = (tok_off != '0) && (17'(tok_off) <= 17'(fill_cnt));
   assign offset_err = offset_err_q;

   // Fill level of history (saturating) and sticky illegal-offset flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fill_cnt     <= '0;
         offset_err_q <= 1'b0;
      end else begin
         if (mem_we && (fill_cnt != 16'(FILL_MAX)))
            fill_cnt <= fill_cnt + 16'd1;
         if (copy_drop)
            offset_err_q <= 1'b1;
      end
   end
`else
   assign copy_ok    = 1'b1;
   assign offset_err = 1'b0;
`endif

   // History buffer write port (contents survive reset, not cleared)
   always_ff @(posedge clock) begin
      if (mem_we)
         hist[wr_ptr] <= mem_wdata;
   end

   // State, pointer and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_byte  <= 8'h00;
         out_valid <= 1'b0;
         ready_en  <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         count     <= count_nxt;
         out_byte  <= out_byte_nxt;
         out_valid <= out_valid_nxt;
         ready_en  <= 1'b1;
      end
   end

   // Next-state, history access and output-register update
   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      count_nxt     = count;
      out_byte_nxt  = out_byte;
      out_valid_nxt = out_valid & ~out_ready;
      mem_we        = 1'b0;
      mem_wdata     = out_byte;
      copy_drop     = 1'b0;

      case (state)
         IDLE: begin
            if (tok_xfer) begin
               if (!in_is_copy) begin
                  mem_we        = 1'b1;
                  mem_wdata     = in_token[7:0];
                  wr_ptr_nxt    = wr_ptr + OFFSET_WIDTH'(1);
                  out_byte_nxt  = in_token[7:0];
                  out_valid_nxt = 1'b1;
               end else if (copy_ok) begin
                  count_nxt  = COUNT_WIDTH'(tok_len) + COUNT_WIDTH'(1);
                  rd_ptr_nxt = wr_ptr - tok_off;
                  state_nxt  = COPY_PRIME;
               end else begin
                  copy_drop = 1'b1;
               end
            end
         end
         COPY_PRIME: begin
            // first read; source always lies strictly behind wr_ptr here
            out_byte_nxt  = hist[rd_ptr];
            out_valid_nxt = 1'b1;
            rd_ptr_nxt    = rd_ptr + OFFSET_WIDTH'(1);
            state_nxt     = COPY;
         end
         COPY: begin
            if (out_xfer) begin
               mem_we     = 1'b1;
               wr_ptr_nxt = wr_ptr + OFFSET_WIDTH'(1);
               count_nxt  = count - COUNT_WIDTH'(1);
               if (count == COUNT_WIDTH'(1)) begin
                  state_nxt = IDLE;
               end else begin
                  // offset 1: the byte being written is the one to read next
                  out_byte_nxt  = (rd_ptr == wr_ptr) ? out_byte : hist[rd_ptr];
                  out_valid_nxt = 1'b1;
                  rd_ptr_nxt    = rd_ptr + OFFSET_WIDTH'(1);
               end
            end
         end
         default: begin
            state_nxt     = IDLE;
            out_valid_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_lzrw_decompressor.sv
// Testbench for lzrw_decompressor (16-byte history, 4-bit length field).
module tb_lzrw_decompressor;

   localparam int unsigned HS = 16;
   localparam int unsigned LW = 4;
   localparam int unsigned TW = 8;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [TW-1:0] in_token;
   logic          in_is_copy;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_byte;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          offset_err;

   lzrw_decompressor #(.HISTORY_SIZE(HS), .LENGTH_WIDTH(LW)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_token   (in_token),
      .in_is_copy (in_is_copy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_byte   (out_byte),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .offset_err (offset_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // reference model: plain LZ77 history plus the expected output stream
   logic [7:0] mhist [HS];
   int         mwp;
   int         mfill;
   logic [7:0] expq [$];
   bit         rand_ready = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mwp   = 0;
      mfill = 0;
      expq.delete();
   endtask

   task automatic model_put(input logic [7:0] b);
      mhist[mwp] = b;
      mwp = (mwp + 1) % HS;
      if (mfill < HS) mfill++;
      expq.push_back(b);
   endtask

   task automatic model_copy(input int len, input int off);
      logic [7:0] b;
      for (int i = 0; i <= len; i++) begin
         b = mhist[(mwp - off + HS) % HS];
         model_put(b);
      end
   endtask

   // one clock cycle: sample before the edge, check held output after it
   task automatic tick(output bit acc);
      bit         hold;
      logic [7:0] hb;
      if (rand_ready) out_ready = ($urandom_range(0, 99) < 70);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (expq.size() == 0) chk("extra_out_byte", {24'h0, out_byte}, 32'hFFFF_FFFF);
         else chk("out_byte", {24'h0, out_byte}, {24'h0, expq.pop_front()});
      end
      hold = out_valid && !out_ready;
      hb   = out_byte;
      @(posedge clock);
      #1;
      if (hold) begin
         chk("stall_valid", {31'h0, out_valid}, 32'd1);
         chk("stall_byte", {24'h0, out_byte}, {24'h0, hb});
      end
   endtask

   task automatic send(input bit is_copy, input logic [7:0] tok, output int waits);
      bit acc;
      in_valid   = 1'b1;
      in_is_copy = is_copy;
      in_token   = tok;
      waits      = 0;
      acc        = 1'b0;
      while (!acc && waits < 100) begin
         tick(acc);
         waits++;
      end
      in_valid = 1'b0;
      chk("token_accepted", {31'h0, acc}, 32'd1);
      if (!is_copy) begin
         model_put(tok);
      end else begin
`ifdef LZRW_DECOMP_OFFSET_CHECK_EN
         if (tok[3:0] != 4'd0 && int'(tok[3:0]) <= mfill)
            model_copy(int'(tok[7:4]), int'(tok[3:0]));
`else
         model_copy(int'(tok[7:4]), int'(tok[3:0]));
`endif
      end
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while ((expq.size() != 0 || busy) && n < 300) begin
         tick(acc);
         n++;
      end
      chk("drain_queue_empty", 32'(expq.size()), 32'd0);
      chk("drain_not_busy", {31'h0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_out_byte", {24'h0, out_byte}, 32'h00);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_offset_err", {31'h0, offset_err}, 32'd0);
      model_reset();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      #1;
      chk("pre_edge_in_ready", {31'h0, in_ready}, 32'd0);
      @(posedge clock);
      #1;
      chk("post_edge_in_ready", {31'h0, in_ready}, 32'd1);
   endtask

   initial begin
      int  w;
      bit  acc;
      int  maxo;
      logic [7:0] tok;

      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_token   = '0;
      in_is_copy = 1'b0;
      out_ready  = 1'b1;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      do_reset();

      // literals A, B, C one per cycle, each visible the cycle after acceptance
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 8'(8'h41 + i), w);
         chk("lit_waits", 32'(w), 32'd1);
         chk("lit_valid_n1", {31'h0, out_valid}, 32'd1);
         chk("lit_byte_n1", {24'h0, out_byte}, 32'(8'h41 + i));
      end
      drain();

      // "abc" then copy len 5 offset 3 -> "abcabc", first byte two cycles later
      send(1'b0, 8'h61, w);
      send(1'b0, 8'h62, w);
      send(1'b0, 8'h63, w);
      drain();
      send(1'b1, 8'h53, w);
      chk("copy_n1_no_valid", {31'h0, out_valid}, 32'd0);
      tick(acc);
      chk("copy_n2_valid", {31'h0, out_valid}, 32'd1);
      chk("copy_n2_byte", {24'h0, out_byte}, 32'h61);
      drain();

      // run-length copy with offset 1 must be gap-free
      send(1'b0, 8'h5A, w);
      send(1'b1, 8'h31, w);
      tick(acc);
      for (int i = 0; i < 4; i++) begin
         chk("rle_no_gap", {31'h0, out_valid}, 32'd1);
         chk("rle_byte", {24'h0, out_byte}, 32'h5A);
         tick(acc);
      end
      drain();

      // stall pattern 1,0,0,1 during a copy
      send(1'b1, 8'h42, w);
      tick(acc);
      out_ready = 1'b1; tick(acc);
      out_ready = 1'b0; tick(acc);
      out_ready = 1'b0; tick(acc);
      out_ready = 1'b1; tick(acc);
      drain();

      // pointer wrap: 20 literals then copy offset 4 length 3 -> 0x10..0x13
      do_reset();
      for (int i = 0; i < 20; i++) send(1'b0, 8'(i), w);
      drain();
      send(1'b1, 8'h34, w);
      tick(acc);
      chk("wrap_first_byte", {24'h0, out_byte}, 32'h10);
      drain();

`ifdef LZRW_DECOMP_OFFSET_CHECK_EN
      // out-of-range offset is dropped and flagged
      do_reset();
      send(1'b0, 8'h11, w);
      send(1'b0, 8'h22, w);
      drain();
      send(1'b1, 8'h05, w);
      tick(acc);
      chk("bad_off_no_output", {31'h0, out_valid}, 32'd0);
      chk("bad_off_err", {31'h0, offset_err}, 32'd1);
      send(1'b0, 8'h77, w);
      chk("after_err_lit", {24'h0, out_byte}, 32'h77);
      drain();
      chk("err_sticky", {31'h0, offset_err}, 32'd1);
`else
      chk("offset_err_tied", {31'h0, offset_err}, 32'd0);
`endif

      // reset in the middle of a long copy aborts it
      do_reset();
      send(1'b0, 8'h99, w);
      send(1'b1, 8'hF1, w);
      tick(acc);
      tick(acc);
      do_reset();
      chk("abort_idle", {31'h0, busy}, 32'd0);

      // randomized token stream with random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if (mfill == 0 || $urandom_range(0, 1) == 0) begin
            send(1'b0, 8'($urandom_range(0, 255)), w);
         end else begin
            maxo = (mfill < 15) ? mfill : 15;
            tok  = {4'($urandom_range(0, 15)), 4'($urandom_range(1, maxo))};
            send(1'b1, tok, w);
         end
      end
      drain();
      rand_ready = 1'b0;
      out_ready  = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
